// File: rtl/intersection_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : intersection_arbiter
// Purpose  : Grants one lane at a time, waits for its red to drop and return,
//            enforces an all-red gap, then moves on. Optional macro
//            ARB_DENSITY_PRIORITY_EN selects highest-density lane first.
// Revision : 1.0 - initial release
// ============================================================================
module intersection_arbiter #(
    parameter int NUM_LANES      = 4,
    parameter int ALL_RED_CYCLES = 3,
    parameter int ACK_TIMEOUT    = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [2*NUM_LANES-1:0] density_i,
    input  logic [NUM_LANES-1:0]   lane_red_i,
    output logic [NUM_LANES-1:0]   grant_o,
    output logic [2:0]             active_lane_o,
    output logic                   busy_o,
    output logic [NUM_LANES-1:0]   fault_o
);

    localparam int C_IDX_W   = $clog2(NUM_LANES);
    localparam int C_TMAX    = (ACK_TIMEOUT > ALL_RED_CYCLES) ? ACK_TIMEOUT : ALL_RED_CYCLES;
    localparam int C_TIMER_W = $clog2(C_TMAX) + 1;
    localparam logic [C_TIMER_W-1:0] C_ACK_LAST = C_TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [C_TIMER_W-1:0] C_CLR_LAST = C_TIMER_W'(ALL_RED_CYCLES - 1);
    localparam logic [C_IDX_W-1:0]   C_LAST_LN  = C_IDX_W'(NUM_LANES - 1);
    localparam logic [NUM_LANES-1:0] C_ONE      = NUM_LANES'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_WAIT_GO  = 3'd2,
        S_WAIT_RED = 3'd3,
        S_CLEAR    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LANES-1:0]   grant_q, grant_d;
    logic [NUM_LANES-1:0]   fault_q, fault_d;
    logic [C_IDX_W-1:0]     sel_q, sel_d;
    logic [C_IDX_W-1:0]     rr_q, rr_d;
    logic                   busy_q, busy_d;
    logic [C_TIMER_W-1:0]   timer_q, timer_d;

    logic [NUM_LANES-1:0]   w_elig;
    logic                   w_any;
    logic [C_IDX_W-1:0]     w_pick;
    logic [C_IDX_W-1:0]     w_idx;
`ifdef ARB_DENSITY_PRIORITY_EN
    logic [1:0]             w_dens [NUM_LANES];
    logic [1:0]             w_best;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_elig
        assign w_elig[i] = (density_i[2*i +: 2] != 2'd0) && !fault_q[i] && lane_red_i[i];
`ifdef ARB_DENSITY_PRIORITY_EN
        assign w_dens[i] = density_i[2*i +: 2];
`endif
    end

    // Scan starts at rr_q, so the lane just served is visited last.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
`ifdef ARB_DENSITY_PRIORITY_EN
        w_best = '0;
`endif
        for (int k = 0; k < NUM_LANES; k++) begin
            w_idx = C_IDX_W'((int'(rr_q) + k) % NUM_LANES);
`ifdef ARB_DENSITY_PRIORITY_EN
            if (w_elig[w_idx] && (!w_any || (w_dens[w_idx] > w_best))) begin
                w_best = w_dens[w_idx];
`else
            if (w_elig[w_idx] && !w_any) begin
`endif
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = '0;
        fault_d = fault_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        timer_d = timer_q;
        unique case (state_q)
            S_IDLE: begin
                // Outputs are loaded on entry so the pulse coincides with GRANT.
                if (w_any) begin
                    state_d = S_GRANT;
                    sel_d   = w_pick;
                    grant_d = C_ONE << w_pick;
                    busy_d  = 1'b1;
                    timer_d = '0;
                end
            end
            S_GRANT: begin
                state_d = S_WAIT_GO;
            end
            S_WAIT_GO: begin
                if (!lane_red_i[sel_q]) begin
                    state_d = S_WAIT_RED;
                end else if (timer_q == C_ACK_LAST) begin
                    fault_d[sel_q] = 1'b1;
                    state_d        = S_CLEAR;
                    timer_d        = '0;
                end else begin
                    timer_d = timer_q + C_TIMER_W'(1);
                end
            end
            S_WAIT_RED: begin
                if (lane_red_i[sel_q]) begin
                    state_d = S_CLEAR;
                    timer_d = '0;
                end
            end
            S_CLEAR: begin
                if (timer_q == C_CLR_LAST) begin
                    busy_d  = 1'b0;
                    rr_d    = (sel_q == C_LAST_LN) ? '0 : sel_q + C_IDX_W'(1);
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + C_TIMER_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            fault_q <= '0;
            sel_q   <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            fault_q <= fault_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            timer_q <= timer_d;
        end
    end

    assign grant_o       = grant_q;
    assign fault_o       = fault_q;
    assign busy_o        = busy_q;
    assign active_lane_o = 3'(sel_q);

endmodule
`default_nettype wire

// File: tb/tb_intersection_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_arbiter
// Purpose  : Directed bench with emulated lane FSMs and a phase-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_arbiter;

    localparam int N       = 4;
    localparam int ALL_RED = 3;
    localparam int ACK_TO  = 8;
    localparam int IDLE_AGE = 100;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b1;
    logic [2*N-1:0] density = '0;
    logic [N-1:0]   lane_red = '1;
    logic [N-1:0]   grant;
    logic [2:0]     active_lane;
    logic           busy;
    logic [N-1:0]   fault;

    intersection_arbiter #(
        .NUM_LANES      (N),
        .ALL_RED_CYCLES (ALL_RED),
        .ACK_TIMEOUT    (ACK_TO)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .density_i     (density),
        .lane_red_i    (lane_red),
        .grant_o       (grant),
        .active_lane_o (active_lane),
        .busy_o        (busy),
        .fault_o       (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // lane emulation
    int           age [N];
    logic [N-1:0] stuck = '0;
    int           last_rise = -1;

    // phase-level model: expected outputs plus where the served lane is in its phase
    logic [N-1:0] exp_grant, exp_fault;
    int           exp_active, rr, m_lane, m_age, m_clr, m_pick;
    bit           exp_busy, m_acked;

    int           dut_log[$], dut_cyc[$], model_log[$], gap_log[$];
    int           fault_cyc = -1;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int choose();
        int pick = -1;
`ifdef ARB_DENSITY_PRIORITY_EN
        int best = -1;
`endif
        for (int k = 0; k < N; k++) begin
            int i = (rr + k) % N;
            if (density[2*i +: 2] != 2'd0 && !exp_fault[i] && lane_red[i]) begin
`ifdef ARB_DENSITY_PRIORITY_EN
                if (int'(density[2*i +: 2]) > best) begin
                    best = int'(density[2*i +: 2]);
                    pick = i;
                end
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        return pick;
    endfunction

    task automatic model_reset();
        exp_grant = '0; exp_fault = '0; exp_active = 0; exp_busy = 0;
        rr = 0; m_lane = 0; m_age = 0; m_clr = -1; m_acked = 0;
    endtask

    // One clock edge of the arbiter, seen through the inputs it sampled.
    task automatic model_step();
        exp_grant = '0;
        if (!exp_busy) begin
            m_pick = choose();
            if (m_pick >= 0) begin
                exp_busy = 1; m_lane = m_pick; exp_active = m_pick;
                exp_grant[m_pick] = 1'b1;
                m_age = 0; m_acked = 0; m_clr = -1;
                model_log.push_back(m_pick);
            end
        end else if (m_clr >= 0) begin
            if (m_clr == ALL_RED - 1) begin
                exp_busy = 0; rr = (m_lane + 1) % N; m_clr = -1;
            end else m_clr++;
        end else if (m_age == 0) m_age = 1;
        else if (m_acked) begin
            if (lane_red[m_lane]) m_clr = 0;
        end else if (!lane_red[m_lane]) m_acked = 1;
        else if (m_age == ACK_TO) begin
            exp_fault[m_lane] = 1'b1; m_clr = 0;
        end else m_age++;
    endtask

    task automatic lane_drive();
        logic old;
        for (int i = 0; i < N; i++) begin
            old = lane_red[i];
            if (!reset_n)             age[i] = IDLE_AGE;
            else if (grant[i])        age[i] = 0;
            else if (age[i] < IDLE_AGE) age[i]++;
            lane_red[i] = stuck[i] | !(age[i] >= 2 && age[i] < 12);
            if (!old && lane_red[i]) last_rise = cyc;
        end
        if (!reset_n) last_rise = -1;
    endtask

    initial begin : monitor
        for (int i = 0; i < N; i++) age[i] = IDLE_AGE;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) model_reset();
            else model_step();
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("active_lane", 32'(active_lane), 32'(exp_active));
            chk("fault", 32'(fault), 32'(exp_fault));
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            chk("grant_width", 32'((prev_grant & grant) != '0), 32'd0);
            prev_grant = grant;
            if (grant != '0) begin
                for (int i = 0; i < N; i++) if (grant[i]) dut_log.push_back(i);
                dut_cyc.push_back(cyc);
                if (last_rise >= 0) gap_log.push_back(cyc - last_rise);
                last_rise = -1;
            end
            if (fault != '0 && fault_cyc < 0) fault_cyc = cyc;
            lane_drive();
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 reset_n = 1'b0; density = '0; stuck = '0;
        @(negedge clk);
        @(negedge clk); #2 reset_n = 1'b1;
        dut_log.delete(); dut_cyc.delete(); model_log.delete(); gap_log.delete();
        fault_cyc = -1;
    endtask

    task automatic set_density(input logic [2*N-1:0] d, output int t0);
        @(negedge clk); #1 density = d;
        t0 = cyc;
    endtask

    task automatic wait_grants(input int n, input string name);
        int budget = 400;
        while (dut_log.size() < n && budget > 0) begin
            @(negedge clk); budget--;
        end
        chk(name, 32'(dut_log.size() >= n), 32'd1);
    endtask

    task automatic check_order(input string name, input int exp_seq[$]);
        for (int k = 0; k < exp_seq.size(); k++) begin
            if (k < dut_log.size())   chk({name, "_dut"}, 32'(dut_log[k]), 32'(exp_seq[k]));
            if (k < model_log.size()) chk({name, "_model"}, 32'(model_log[k]), 32'(exp_seq[k]));
        end
    endtask

    initial begin : main
        int t0;
        int budget;
        int seq[$];
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // round-robin across all lanes, all-red gap between phases
        set_density(8'b01_01_01_01, t0);
        wait_grants(5, "rr_progress");
        seq = '{0, 1, 2, 3, 0};
        check_order("rr_order", seq);
        if (dut_cyc.size() > 0) chk("first_grant_latency", 32'(dut_cyc[0] - t0), 32'd1);
        for (int k = 0; k < 4 && k < gap_log.size(); k++)
            chk("clear_gap", 32'(gap_log[k]), 32'(ALL_RED + 2));

        // reset in the middle of lane 1's green/yellow
        wait_grants(6, "rst_progress");
        budget = 50;
        while (!(busy && active_lane == 3'd1 && !lane_red[1]) && budget > 0) begin
            @(negedge clk); budget--;
        end
        chk("rst_reached_wait_red", 32'(budget > 0), 32'd1);
        @(negedge clk); #2 reset_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_active", 32'(active_lane), 32'd0);
        #1 reset_n = 1'b1;
        dut_log.delete(); dut_cyc.delete(); model_log.delete(); gap_log.delete();

        // lanes 0 and 2 have no demand
        do_reset();
        set_density(8'b11_00_01_00, t0);
        wait_grants(3, "skip_progress");
        seq = '{1, 3, 1};
        check_order("skip_order", seq);

        // lane 2 never leaves red: faulted once, then skipped
        do_reset();
        stuck = 4'b0100;
        set_density(8'b01_01_01_01, t0);
        wait_grants(7, "timeout_progress");
        seq = '{0, 1, 2, 3, 0, 1, 3};
        check_order("timeout_order", seq);
        chk("timeout_fault_vec", 32'(fault), 32'b0100);
        if (dut_cyc.size() > 2) chk("timeout_delay", 32'(fault_cyc - dut_cyc[2]), 32'(ACK_TO + 1));

        // mixed densities: lane3=1 lane2=3 lane1=3 lane0=2
        do_reset();
        set_density(8'b01_11_11_10, t0);
        wait_grants(4, "density_progress");
`ifdef ARB_DENSITY_PRIORITY_EN
        seq = '{1, 2, 1, 2};
`else
        seq = '{0, 1, 2, 3};
`endif
        check_order("density_order", seq);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
